// File: rtl/cfi_lpad_tracker.sv
// Forward-edge CFI landing-pad expectation tracker for the ID stage.
// Arms on tracked indirect jumps, checks the next accepted instruction, saves/restores ELP.
module cfi_lpad_tracker #(
   parameter int unsigned LABEL_W = 20,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               lpad_en_i,
   input  logic               instr_accept_i,
   input  logic               is_indirect_jmp_i,
   input  logic [LABEL_W-1:0] expected_label_i,
   input  logic               is_lpad_i,
   input  logic [LABEL_W-1:0] lpad_label_i,
   input  logic               flush_i,
   input  logic               flush_keep_i,
   input  logic               trap_i,
   input  logic               xret_i,
   input  logic               pelp_i,
   input  logic               cnt_clr_i,
   output logic               lp_fault_o,
   output logic               elp_o,
   output logic               pelp_o,
   output logic [CNT_W-1:0]   fault_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPECT = 2'd1,
      FAULT  = 2'd2
   } state_e;

   state_e             state_q;
   logic [LABEL_W-1:0] lbl_q;
   logic               elp_q;
   logic               pelp_q;
   logic [CNT_W-1:0]   cnt_q;

   logic match;
   logic normal_path;
   logic to_fault;
   logic cnt_max;

   // Label 0 armed by the jump (or restored by xRET) accepts any LPAD.
   assign match = is_lpad_i && ((lbl_q == '0) || (lpad_label_i == lbl_q));

   assign lp_fault_o = instr_accept_i && lpad_en_i &&
                       (((state_q == EXPECT) && !match) || (state_q == FAULT));

   assign normal_path = !xret_i && !trap_i && !flush_i && lpad_en_i;
   assign to_fault    = normal_path && instr_accept_i && (state_q == EXPECT) && !match;
   assign cnt_max     = &cnt_q;

   // Expectation FSM; elp_q tracks (next state != IDLE) so it stays a plain flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lbl_q   <= '0;
         elp_q   <= 1'b0;
         pelp_q  <= 1'b0;
      end else if (xret_i) begin
         if (lpad_en_i && pelp_i) begin
            state_q <= EXPECT;
            elp_q   <= 1'b1;
         end else begin
            state_q <= IDLE;
            elp_q   <= 1'b0;
         end
         lbl_q  <= '0;
         pelp_q <= 1'b0;
      end else if (trap_i) begin
         pelp_q  <= (state_q != IDLE);
         state_q <= IDLE;
         elp_q   <= 1'b0;
      end else if (!lpad_en_i) begin
         state_q <= IDLE;
         elp_q   <= 1'b0;
      end else if (flush_i) begin
         // A mispredicted armed jump keeps its expectation; a fault never survives a flush.
         if (!flush_keep_i || (state_q == FAULT)) begin
            state_q <= IDLE;
            elp_q   <= 1'b0;
         end
      end else if (instr_accept_i) begin
         case (state_q)
            IDLE: begin
               if (is_indirect_jmp_i) begin
                  state_q <= EXPECT;
                  lbl_q   <= expected_label_i;
                  elp_q   <= 1'b1;
               end
            end
            EXPECT: begin
               if (match) begin
                  state_q <= IDLE;
                  elp_q   <= 1'b0;
               end else begin
                  state_q <= FAULT;
                  elp_q   <= 1'b1;
               end
            end
            FAULT: begin
               state_q <= FAULT;
               elp_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               elp_q   <= 1'b0;
            end
         endcase
      end
   end

   // Saturating violation counter; clear beats a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (cnt_clr_i) begin
         cnt_q <= '0;
      end else if (to_fault && !cnt_max) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign elp_o       = elp_q;
   assign pelp_o      = pelp_q;
   assign fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_cfi_lpad_tracker.sv
// Bench for cfi_lpad_tracker: directed vector table, counter saturation on a narrow
// instance, then random traffic against an event-level model of the landing-pad rules.
module tb_cfi_lpad_tracker;

   localparam int unsigned LW  = 20;
   localparam int unsigned CW  = 16;
   localparam int unsigned CWS = 6;
   localparam int SAT_S = 63;
   localparam int SAT_M = 65535;

   localparam int K_RST    = 0;
   localparam int K_NOP    = 1;
   localparam int K_JMP    = 2;
   localparam int K_LPAD   = 3;
   localparam int K_ADD    = 4;
   localparam int K_FLUSH  = 5;
   localparam int K_FLUSHK = 6;
   localparam int K_TRAP   = 7;
   localparam int K_XRET   = 8;
   localparam int K_XT     = 9;
   localparam int K_CLRADD = 10;

   typedef struct {
      bit rst, en, acc, jmp, lpad, flush, keep, trap, xret, pelp, clr;
      int xl, ll;
      bit ef, ee, ep;
      int ec;
   } vec_t;

   logic clk = 1'b0;
   logic rst, en, acc, jmp, lpad, flush, keep, trap, xret, pelp_in, clr;
   logic [LW-1:0] xlbl, llbl;
   logic fault, elp, pelp;
   logic [CW-1:0] cnt;
   logic fault_s, elp_s, pelp_s;
   logic [CWS-1:0] cnt_s;

   int errors = 0;
   int checks = 0;

   bit m_elp, m_bad, m_pelp;
   int m_lbl, m_cnt, m_cnt_s;

   always #5 clk = ~clk;

   cfi_lpad_tracker #(.LABEL_W(LW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .lpad_en_i(en), .instr_accept_i(acc),
      .is_indirect_jmp_i(jmp), .expected_label_i(xlbl), .is_lpad_i(lpad),
      .lpad_label_i(llbl), .flush_i(flush), .flush_keep_i(keep), .trap_i(trap),
      .xret_i(xret), .pelp_i(pelp_in), .cnt_clr_i(clr), .lp_fault_o(fault),
      .elp_o(elp), .pelp_o(pelp), .fault_cnt_o(cnt)
   );

   cfi_lpad_tracker #(.LABEL_W(LW), .CNT_W(CWS)) dut_s (
      .clk_i(clk), .rst_i(rst), .lpad_en_i(en), .instr_accept_i(acc),
      .is_indirect_jmp_i(jmp), .expected_label_i(xlbl), .is_lpad_i(lpad),
      .lpad_label_i(llbl), .flush_i(flush), .flush_keep_i(keep), .trap_i(trap),
      .xret_i(xret), .pelp_i(pelp_in), .cnt_clr_i(clr), .lp_fault_o(fault_s),
      .elp_o(elp_s), .pelp_o(pelp_s), .fault_cnt_o(cnt_s)
   );

   task automatic check(input string name, input int id, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
      end
   endtask

   function automatic vec_t mk(input int k, input int arg, input bit e,
                               input bit ef, input bit ee, input bit ep, input int ec);
      vec_t v;
      v = '{default: 0};
      v.en = e; v.ef = ef; v.ee = ee; v.ep = ep; v.ec = ec;
      case (k)
         K_RST:    v.rst = 1'b1;
         K_JMP:    begin v.acc = 1'b1; v.jmp = 1'b1; v.xl = arg; end
         K_LPAD:   begin v.acc = 1'b1; v.lpad = 1'b1; v.ll = arg; end
         K_ADD:    v.acc = 1'b1;
         K_FLUSH:  v.flush = 1'b1;
         K_FLUSHK: begin v.flush = 1'b1; v.keep = 1'b1; end
         K_TRAP:   begin v.trap = 1'b1; v.flush = 1'b1; end
         K_XRET:   begin v.xret = 1'b1; v.pelp = (arg != 0); end
         K_XT:     begin v.xret = 1'b1; v.trap = 1'b1; v.flush = 1'b1; v.pelp = 1'b1; end
         K_CLRADD: begin v.clr = 1'b1; v.acc = 1'b1; end
         default:  ;
      endcase
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; en = v.en; acc = v.acc; jmp = v.jmp; lpad = v.lpad;
      flush = v.flush; keep = v.keep; trap = v.trap; xret = v.xret;
      pelp_in = v.pelp; clr = v.clr;
      xlbl = LW'(v.xl); llbl = LW'(v.ll);
   endtask

   function automatic bit lpad_ok();
      return lpad && (m_lbl == 0 || int'(llbl) == m_lbl);
   endfunction

   function automatic bit model_fault();
      return acc && en && (m_bad || (m_elp && !lpad_ok()));
   endfunction

   // Event-level rules: which event wins this cycle, and what it does to the expectation.
   task automatic model_step();
      bit viol;
      viol = 1'b0;
      if (rst) begin
         m_elp = 0; m_bad = 0; m_pelp = 0; m_lbl = 0;
      end else if (xret) begin
         m_elp = en && pelp_in; m_bad = 0; m_lbl = 0; m_pelp = 0;
      end else if (trap) begin
         m_pelp = m_elp; m_elp = 0; m_bad = 0;
      end else if (!en) begin
         m_elp = 0; m_bad = 0;
      end else if (flush) begin
         if (!keep || m_bad) begin m_elp = 0; m_bad = 0; end
      end else if (acc) begin
         if (!m_elp) begin
            if (jmp) begin m_elp = 1; m_lbl = int'(xlbl); end
         end else if (!m_bad) begin
            if (lpad_ok()) m_elp = 0;
            else begin m_bad = 1; viol = 1; end
         end
      end
      if (rst || clr) begin
         m_cnt = 0; m_cnt_s = 0;
      end else if (viol) begin
         m_cnt   = (m_cnt   < SAT_M) ? m_cnt + 1   : SAT_M;
         m_cnt_s = (m_cnt_s < SAT_S) ? m_cnt_s + 1 : SAT_S;
      end
   endtask

   task automatic apply(input vec_t v, input bit use_model, input int id);
      bit xf, xe, xp;
      int xc, xcs;
      drive(v);
      #1;
      xf = use_model ? model_fault() : v.ef;
      check("lp_fault", id, int'(fault), int'(xf));
      check("lp_fault_s", id, int'(fault_s), int'(xf));
      model_step();
      if (use_model) begin
         xe = m_elp; xp = m_pelp; xc = m_cnt; xcs = m_cnt_s;
      end else begin
         xe = v.ee; xp = v.ep; xc = v.ec; xcs = v.ec;
      end
      @(posedge clk);
      #1;
      check("elp", id, int'(elp), int'(xe));
      check("pelp", id, int'(pelp), int'(xp));
      check("fault_cnt", id, int'(cnt), xc);
      check("elp_s", id, int'(elp_s), int'(xe));
      check("fault_cnt_s", id, int'(cnt_s), xcs);
      @(negedge clk);
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      drive(mk(K_RST, 0, 1'b1, 0, 0, 0, 0));
      m_elp = 0; m_bad = 0; m_pelp = 0; m_lbl = 0; m_cnt = 0; m_cnt_s = 0;

      //                 kind      arg      en  flt elp pelp cnt
      tbl.push_back(mk(K_RST,    0,       1, 0, 0, 0, 0));
      tbl.push_back(mk(K_JMP,    'hABC,   1, 0, 1, 0, 0));
      tbl.push_back(mk(K_NOP,    0,       1, 0, 1, 0, 0));
      tbl.push_back(mk(K_LPAD,   'hABC,   1, 0, 0, 0, 0));
      tbl.push_back(mk(K_ADD,    0,       1, 0, 0, 0, 0));
      tbl.push_back(mk(K_JMP,    1,       1, 0, 1, 0, 0));
      tbl.push_back(mk(K_ADD,    0,       1, 1, 1, 0, 1));
      tbl.push_back(mk(K_ADD,    0,       1, 1, 1, 0, 1));
      tbl.push_back(mk(K_ADD,    0,       1, 1, 1, 0, 1));
      tbl.push_back(mk(K_TRAP,   0,       1, 0, 0, 1, 1));
      tbl.push_back(mk(K_JMP,    0,       1, 0, 1, 1, 1));
      tbl.push_back(mk(K_LPAD,   'h12345, 1, 0, 0, 1, 1));
      tbl.push_back(mk(K_JMP,    5,       1, 0, 1, 1, 1));
      tbl.push_back(mk(K_LPAD,   6,       1, 1, 1, 1, 2));
      tbl.push_back(mk(K_FLUSH,  0,       1, 0, 0, 1, 2));
      tbl.push_back(mk(K_JMP,    7,       1, 0, 1, 1, 2));
      tbl.push_back(mk(K_FLUSHK, 0,       1, 0, 1, 1, 2));
      tbl.push_back(mk(K_LPAD,   7,       1, 0, 0, 1, 2));
      tbl.push_back(mk(K_JMP,    8,       1, 0, 1, 1, 2));
      tbl.push_back(mk(K_FLUSH,  0,       1, 0, 0, 1, 2));
      tbl.push_back(mk(K_ADD,    0,       1, 0, 0, 1, 2));
      tbl.push_back(mk(K_XRET,   1,       1, 0, 1, 0, 2));
      tbl.push_back(mk(K_LPAD,   'h55,    1, 0, 0, 0, 2));
      tbl.push_back(mk(K_XRET,   1,       0, 0, 0, 0, 2));
      tbl.push_back(mk(K_JMP,    9,       1, 0, 1, 0, 2));
      tbl.push_back(mk(K_TRAP,   0,       1, 0, 0, 1, 2));
      tbl.push_back(mk(K_XT,     1,       1, 0, 1, 0, 2));
      tbl.push_back(mk(K_JMP,    3,       1, 1, 1, 0, 3));
      tbl.push_back(mk(K_FLUSHK, 0,       1, 0, 0, 0, 3));
      tbl.push_back(mk(K_JMP,    4,       0, 0, 0, 0, 3));
      tbl.push_back(mk(K_JMP,    4,       1, 0, 1, 0, 3));
      tbl.push_back(mk(K_ADD,    0,       0, 0, 0, 0, 3));
      tbl.push_back(mk(K_JMP,    2,       1, 0, 1, 0, 3));
      tbl.push_back(mk(K_CLRADD, 0,       1, 1, 1, 0, 0));
      tbl.push_back(mk(K_TRAP,   0,       1, 0, 0, 1, 0));
      tbl.push_back(mk(K_JMP,    1,       1, 0, 1, 1, 0));
      tbl.push_back(mk(K_ADD,    0,       1, 1, 1, 1, 1));
      tbl.push_back(mk(K_TRAP,   0,       1, 0, 0, 1, 1));
      tbl.push_back(mk(K_JMP,    1,       1, 0, 1, 1, 1));
      tbl.push_back(mk(K_RST,    0,       1, 0, 0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, i);

      // Saturation on the narrow instance: xRET with PELP re-arms a wildcard, ADD violates it.
      apply(mk(K_JMP, 1, 1, 0, 0, 0, 0), 1'b1, 1000);
      apply(mk(K_ADD, 0, 1, 0, 0, 0, 0), 1'b1, 1001);
      for (int i = 0; i < SAT_S + 7; i++) begin
         apply(mk(K_XRET, 1, 1, 0, 0, 0, 0), 1'b1, 1002 + 2 * i);
         apply(mk(K_ADD, 0, 1, 0, 0, 0, 0), 1'b1, 1003 + 2 * i);
      end
      check("sat_small", 1200, int'(cnt_s), SAT_S);
      check("sat_main", 1201, int'(cnt), SAT_S + 8);
      apply(mk(K_CLRADD, 0, 1, 0, 0, 0, 0), 1'b1, 1202);
      check("clr_small", 1203, int'(cnt_s), 0);

      // Random traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         v = '{default: 0};
         v.rst   = ($urandom_range(199) == 0);
         v.en    = ($urandom_range(7) != 0);
         v.acc   = ($urandom_range(1) == 0);
         v.jmp   = v.acc && ($urandom_range(3) == 0);
         v.lpad  = v.acc && !v.jmp && ($urandom_range(2) == 0);
         v.xl    = ($urandom_range(9) == 0) ? int'($urandom_range(20'hFFFFF)) : int'($urandom_range(3));
         v.ll    = ($urandom_range(9) == 0) ? int'($urandom_range(20'hFFFFF)) : int'($urandom_range(3));
         v.trap  = ($urandom_range(19) == 0);
         v.flush = v.trap || ($urandom_range(9) == 0);
         v.keep  = v.flush && ($urandom_range(1) == 0);
         v.xret  = ($urandom_range(24) == 0);
         v.pelp  = ($urandom_range(1) == 0);
         v.clr   = ($urandom_range(49) == 0);
         apply(v, 1'b1, 2000 + i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cfi_lpad_tracker.md
# cfi_lpad_tracker

Tracks the forward-edge CFI landing-pad expectation (ELP) for the decode stream. It sits beside the ID stage and watches every instruction accepted from fetch into the ID/issue register. After an indirect jump it requires the next accepted instruction to be a landing pad with a matching label, and flags a violation combinationally so the ID stage can fold it into the entry's exception. It also saves and restores ELP across traps and xRET.

## Interface
- LABEL_W, 20: landing-pad label width; label 0 is wildcard.
- CNT_W, 16: violation counter width.

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- lpad_en_i  in  1  xLPAD enable for current privilege level
- instr_accept_i  in  1  decoded instruction enters ID/issue register this cycle (fetch valid & ready)
- is_indirect_jmp_i  in  1  accepted instr is a tracked indirect jump (JALR/C.JR/C.JALR, rs1 not x1/x5/x7)
- expected_label_i  in  LABEL_W  label to require, sampled with the jump
- is_lpad_i  in  1  accepted instr is LPAD
- lpad_label_i  in  LABEL_W  immediate label of accepted LPAD
- flush_i  in  1  pipeline flush
- flush_keep_i  in  1  with flush_i: flushing instr is the armed jump itself (mispredict); keep expectation
- trap_i  in  1  trap taken this cycle (always with flush_i)
- xret_i  in  1  MRET/SRET commits this cycle
- pelp_i  in  1  PELP value restored by xRET
- cnt_clr_i  in  1  clear violation counter
- lp_fault_o  out  1  accepted instr violates landing-pad rule (combinational)
- elp_o  out  1  expectation armed (state != IDLE)
- pelp_o  out  1  ELP saved at last trap
- fault_cnt_o  out  CNT_W  saturating violation count

## Operation
- States: IDLE, EXPECT, FAULT. Label register lbl_q (LABEL_W).
- Match condition: is_lpad_i && (lbl_q == 0 || lpad_label_i == lbl_q).
- IDLE: accept with is_indirect_jmp_i and lpad_en_i -> EXPECT, lbl_q <= expected_label_i. Otherwise stays.
- EXPECT, accept with match -> IDLE, or EXPECT again if also an indirect jump (not possible for LPAD; treat as IDLE).
- EXPECT, accept without match -> FAULT, lp_fault_o=1 that cycle.
- FAULT: lp_fault_o=1 on every accept (younger instrs are squashed anyway). Leaves only via flush/trap/xret/reset.
- lp_fault_o = instr_accept_i && lpad_en_i && ((EXPECT && !match) || FAULT).
- Priority per cycle, highest first:
  - rst_i
  - xret_i: state <= (lpad_en_i && pelp_i) ? EXPECT : IDLE; lbl_q <= 0 (wildcard); pelp_o <= 0.
  - trap_i: pelp_o <= (state != IDLE); state <= IDLE.
  - flush_i && flush_keep_i: state and lbl_q unchanged, except FAULT -> IDLE.
  - flush_i alone: state <= IDLE.
  - Normal accept transitions.
- lpad_en_i low: no arming, lp_fault_o=0, next state IDLE regardless of current state. Flush, trap and xret handling still applies, so pelp_o still saves.
- Counter: +1 on each EXPECT->FAULT transition; saturates at all-ones; cnt_clr_i zeros it (cnt_clr_i beats increment in the same cycle).

## Timing
- Reset values: state IDLE, lbl_q 0, elp_o 0, pelp_o 0, fault_cnt_o 0, lp_fault_o 0 (inputs permitting).
- Arm latency: jump accepted in cycle N; the check applies to the first accept in N+1 or later. The jump's own accept is never checked against a prior expectation unless in EXPECT, in which case the jump is a fault.
- lp_fault_o is combinational in the accept cycle, with zero latency, for the ID stage to merge into the entry's ex field before the register.
- Stalls (no accept) hold state indefinitely.
- elp_o and pelp_o are registered, updated one cycle after the event.
- Accept in the same cycle as flush_i: flush wins and the accept is ignored for state purposes. lp_fault_o is still computed from the pre-flush state.

## Test plan
- Arm/clear: accept JALR with label 0x00ABC, then accept LPAD with label 0x00ABC -> elp_o 1 then 0, lp_fault_o never 1, count 0.
- Violation: arm with 0x00001, accept ADD -> lp_fault_o=1 in that cycle. Then accept 2 more -> lp_fault_o=1 each. Count 1. Then trap_i+flush_i -> state IDLE, pelp_o=1.
- Wildcard/mismatch: arm with 0 and accept LPAD label 0x12345 -> pass. Arm with 0x5 and accept LPAD 0x6 -> fault.
- Flush: arm, then flush_i && flush_keep_i -> elp_o stays 1. Arm again, then flush_i alone -> elp_o 0, and next ADD is not faulted.
- xRET restore: pelp_i=1, xret_i with lpad_en_i=1 -> EXPECT with wildcard. xret_i with lpad_en_i=0 -> IDLE. xret_i and trap_i in the same cycle -> xret result.
- Counter: force 0xFFFF+2 violations -> saturates at 0xFFFF. cnt_clr_i with a simultaneous violation -> 0. rst_i mid-EXPECT -> all outputs return to reset values the next cycle.
